// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types: control bundle, ALU op codes, constants.
// Imported by the ID/EX stage, its hazard unit and the ID/EX interface.
package mips_pkg;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_NOR = 4'd5,
    ALU_SLT = 4'd6,
    ALU_SLL = 4'd7,
    ALU_SRL = 4'd8,
    ALU_SRA = 4'd9,
    ALU_LUI = 4'd10
  } alu_op_t;

  typedef struct packed {
    logic    RegWrite;
    logic    MemRead;
    logic    MemWrite;
    logic    MemToReg;
    logic    ALUSrc;
    alu_op_t ALUOp;
  } ctrl_t;

  localparam int unsigned REG_ZERO = 0;

  // All-zero control: no register or memory write, so it never
  // matches in forwarding and never disturbs architectural state.
  localparam ctrl_t CTRL_BUBBLE = ctrl_t'('0);

endpackage

// File: rtl/id_ex_stage_if.sv
// ID -> ID/EX bundle: decoded ID inputs, flush, stall and IDEX outputs.
// slave: the stage (reads id_*/flush, drives stall/IDEX_*); master: driver.
interface id_ex_stage_if
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
);

  logic              id_valid;
  logic [REG_W-1:0]  id_rs;
  logic [REG_W-1:0]  id_rt;
  logic [REG_W-1:0]  id_dest;
  logic              id_uses_rt;
  ctrl_t             id_ctrl;
  logic [DATA_W-1:0] id_rdata1;
  logic [DATA_W-1:0] id_rdata2;
  logic [DATA_W-1:0] id_imm;
  logic              flush;
  logic              stall;

  logic              IDEX_valid;
  logic [REG_W-1:0]  IDEX_src1;
  logic [REG_W-1:0]  IDEX_src2;
  logic [REG_W-1:0]  IDEX_dest;
  ctrl_t             IDEX_ctrl;
  logic [DATA_W-1:0] IDEX_rdata1;
  logic [DATA_W-1:0] IDEX_rdata2;
  logic [DATA_W-1:0] IDEX_imm;

  modport master (
    output id_valid, id_rs, id_rt, id_dest, id_uses_rt,
    output id_ctrl, id_rdata1, id_rdata2, id_imm, flush,
    input  stall,
    input  IDEX_valid, IDEX_src1, IDEX_src2, IDEX_dest,
    input  IDEX_ctrl, IDEX_rdata1, IDEX_rdata2, IDEX_imm
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_dest, id_uses_rt,
    input  id_ctrl, id_rdata1, id_rdata2, id_imm, flush,
    output stall,
    output IDEX_valid, IDEX_src1, IDEX_src2, IDEX_dest,
    output IDEX_ctrl, IDEX_rdata1, IDEX_rdata2, IDEX_imm
  );

endinterface

// File: rtl/id_ex_hazard.sv
// Load-use detector: stalls ID one cycle when the load in EX feeds it.
// In: EX load info, ID sources, flush. Out: stall (combinational).
module id_ex_hazard
  import mips_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic             idex_valid,
  input  logic             idex_mem_read,
  input  logic [REG_W-1:0] idex_dest,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             flush,
  output logic             stall
);

  logic rs_hit;
  logic rt_hit;
  logic load_live;

  assign rs_hit = (idex_dest == id_rs);
  assign rt_hit = id_uses_rt && (idex_dest == id_rt);

  // $zero is never really written, so a load to it never hazards.
  assign load_live = idex_valid && idex_mem_read
                  && (idex_dest != REG_W'(REG_ZERO));

  // A taken branch discards ID anyway; holding it would be wasted.
  assign stall = !flush && load_live && id_valid
              && (rs_hit || rt_hit);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall and flush bubbling.
// Ports: clock, reset, bus (id_ex_stage_if.slave); stall_count if ID_EX_STALL_COUNT_EN.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input logic clock,
  input logic reset,
`ifdef ID_EX_STALL_COUNT_EN
  output logic [31:0] stall_count,
`endif
  id_ex_stage_if.slave bus
);

  logic stall;
  logic load_bubble;

  id_ex_hazard #(
    .REG_W (REG_W)
  ) u_hazard (
    .idex_valid    (bus.IDEX_valid),
    .idex_mem_read (bus.IDEX_ctrl.MemRead),
    .idex_dest     (bus.IDEX_dest),
    .id_valid      (bus.id_valid),
    .id_rs         (bus.id_rs),
    .id_rt         (bus.id_rt),
    .id_uses_rt    (bus.id_uses_rt),
    .flush         (bus.flush),
    .stall         (stall)
  );

  assign bus.stall = stall;

  assign load_bubble = reset || bus.flush
                    || stall || !bus.id_valid;

  always_ff @(posedge clock) begin
    if (load_bubble) begin
      bus.IDEX_valid  <= 1'b0;
      bus.IDEX_src1   <= '0;
      bus.IDEX_src2   <= '0;
      bus.IDEX_dest   <= '0;
      bus.IDEX_ctrl   <= CTRL_BUBBLE;
      bus.IDEX_rdata1 <= '0;
      bus.IDEX_rdata2 <= '0;
      bus.IDEX_imm    <= '0;
    end else begin
      bus.IDEX_valid  <= 1'b1;
      bus.IDEX_src1   <= bus.id_rs;
      bus.IDEX_src2   <= bus.id_rt;
      bus.IDEX_dest   <= bus.id_dest;
      bus.IDEX_ctrl   <= bus.id_ctrl;
      bus.IDEX_rdata1 <= bus.id_rdata1;
      bus.IDEX_rdata2 <= bus.id_rdata2;
      bus.IDEX_imm    <= bus.id_imm;
    end
  end

`ifdef ID_EX_STALL_COUNT_EN
  logic [31:0] cnt_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (stall) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign stall_count = cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Random + directed bench for id_ex_stage against a rule-level model.
// Optional counter checks need ID_EX_STALL_COUNT_EN.
module tb_id_ex_stage;
  import mips_pkg::*;

  logic clock = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  logic last_stall;

  always #5 clock = ~clock;

  id_ex_stage_if #(.DATA_W(32), .REG_W(5)) bus ();

`ifdef ID_EX_STALL_COUNT_EN
  logic [31:0] stall_count;
  logic [31:0] exp_cnt;
  id_ex_stage dut (
    .clock       (clock),
    .reset       (reset),
    .stall_count (stall_count),
    .bus         (bus)
  );
`else
  id_ex_stage dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );
`endif

  typedef struct packed {
    logic        v;
    logic [4:0]  s1;
    logic [4:0]  s2;
    logic [4:0]  d;
    ctrl_t       c;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] im;
  } idex_m_t;

  idex_m_t m;

  localparam ctrl_t C_LW  = '{RegWrite:1'b1, MemRead:1'b1,
    MemWrite:1'b0, MemToReg:1'b1, ALUSrc:1'b1, ALUOp:ALU_ADD};
  localparam ctrl_t C_ADD = '{RegWrite:1'b1, MemRead:1'b0,
    MemWrite:1'b0, MemToReg:1'b0, ALUSrc:1'b0, ALUOp:ALU_ADD};
  localparam ctrl_t C_SW  = '{RegWrite:1'b0, MemRead:1'b0,
    MemWrite:1'b1, MemToReg:1'b0, ALUSrc:1'b1, ALUOp:ALU_ADD};

  task automatic check(string tag, logic [127:0] obs,
                       logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  function automatic idex_m_t observed();
    idex_m_t o;
    o.v  = bus.IDEX_valid;
    o.s1 = bus.IDEX_src1;
    o.s2 = bus.IDEX_src2;
    o.d  = bus.IDEX_dest;
    o.c  = bus.IDEX_ctrl;
    o.r1 = bus.IDEX_rdata1;
    o.r2 = bus.IDEX_rdata2;
    o.im = bus.IDEX_imm;
    return o;
  endfunction

  // Load in EX whose result the ID instruction needs, unless flushed.
  function automatic logic model_stall();
    logic needs;
    needs = (m.d == bus.id_rs)
         || (bus.id_uses_rt && m.d == bus.id_rt);
    return m.v && m.c.MemRead && m.d != 0 && bus.id_valid
        && needs && !bus.flush;
  endfunction

  task automatic drv(logic v, int rs, int rt, int d, logic u,
                     ctrl_t c, logic fl, logic rst);
    bus.id_valid   = v;
    bus.id_rs      = 5'(rs);
    bus.id_rt      = 5'(rt);
    bus.id_dest    = 5'(d);
    bus.id_uses_rt = u;
    bus.id_ctrl    = c;
    bus.id_rdata1  = $urandom;
    bus.id_rdata2  = $urandom;
    bus.id_imm     = $urandom;
    bus.flush      = fl;
    reset          = rst;
  endtask

  // Inputs already driven; check stall, clock once, check IDEX.
  task automatic step();
    logic    s_exp;
    idex_m_t nxt;
    #1;
    s_exp = model_stall();
    check("stall", 128'(bus.stall), 128'(s_exp));
    last_stall = bus.stall;
    if (reset || bus.flush || s_exp || !bus.id_valid) begin
      nxt = '0;
    end else begin
      nxt = '{1'b1, bus.id_rs, bus.id_rt, bus.id_dest,
              bus.id_ctrl, bus.id_rdata1, bus.id_rdata2,
              bus.id_imm};
    end
`ifdef ID_EX_STALL_COUNT_EN
    if (reset) exp_cnt = 0;
    else if (s_exp) exp_cnt = exp_cnt + 1;
`endif
    @(posedge clock);
    #1;
    m = nxt;
    check("idex", 128'(observed()), 128'(m));
`ifdef ID_EX_STALL_COUNT_EN
    check("stall_count", 128'(stall_count), 128'(exp_cnt));
`endif
  endtask

  task automatic lw(int d);
    drv(1, 3, 4, d, 0, C_LW, 0, 0);
    step();
  endtask

  initial begin
    m = '0;
`ifdef ID_EX_STALL_COUNT_EN
    exp_cnt = 0;
`endif
    drv(1, 1, 2, 3, 1, C_ADD, 0, 1);
    @(posedge clock);
    #1;
    step();
    check("reset_valid", 128'(bus.IDEX_valid), 128'(0));

    // lw $8 then add reading $8: one stall, bubble, then add
    lw(8);
    drv(1, 8, 9, 10, 1, C_ADD, 0, 0);
    step();
    check("r030_stall", 128'(last_stall), 128'(1));
    check("r030_bubble", 128'(bus.IDEX_valid), 128'(0));
    step();
    check("r030_nostall", 128'(last_stall), 128'(0));
    check("r030_src1", 128'(bus.IDEX_src1), 128'(8));

    // sw using $8 via rt, with and without uses_rt
    lw(8);
    drv(1, 2, 8, 0, 1, C_SW, 0, 0);
    step();
    check("r031_rt_stall", 128'(last_stall), 128'(1));
    step();
    lw(8);
    drv(1, 2, 8, 0, 0, C_SW, 0, 0);
    step();
    check("r031_no_rt", 128'(last_stall), 128'(0));

    // load to $zero never stalls
    lw(0);
    drv(1, 0, 0, 5, 1, C_ADD, 0, 0);
    step();
    check("r032_stall", 128'(last_stall), 128'(0));
    check("r032_valid", 128'(bus.IDEX_valid), 128'(1));

    // flush overrides a hazard
    lw(8);
    drv(1, 8, 1, 5, 1, C_ADD, 1, 0);
    step();
    check("r033_stall", 128'(last_stall), 128'(0));
    check("r033_ctrl", 128'(bus.IDEX_ctrl), 128'(0));

    // reset during a stall cycle
    lw(8);
    drv(1, 8, 1, 5, 1, C_ADD, 0, 1);
    step();
    check("r034_valid", 128'(bus.IDEX_valid), 128'(0));
    drv(1, 8, 1, 5, 1, C_ADD, 0, 0);
    #1;
    check("r034_stall", 128'(bus.stall), 128'(0));
`ifdef ID_EX_STALL_COUNT_EN
    check("r034_cnt", 128'(stall_count), 128'(0));
`endif
    step();

`ifdef ID_EX_STALL_COUNT_EN
    drv(0, 0, 0, 0, 0, C_ADD, 0, 1);
    step();
    for (int k = 0; k < 3; k++) begin
      lw(8);
      drv(1, 8, 1, 5, 1, C_ADD, 0, 0);
      step();
      step();
    end
    check("r035_three", 128'(stall_count), 128'(3));
    force dut.cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.cnt_q;
    exp_cnt = 32'hFFFF_FFFF;
    lw(8);
    drv(1, 8, 1, 5, 1, C_ADD, 0, 0);
    step();
    check("r035_wrap", 128'(stall_count), 128'(0));
    step();
`endif

    // random traffic on a small register set to provoke hazards
    for (int i = 0; i < 400; i++) begin
      ctrl_t c;
      c = ctrl_t'(9'($urandom));
      drv(($urandom_range(0, 9) < 8),
          $urandom_range(0, 3), $urandom_range(0, 3),
          $urandom_range(0, 3), 1'($urandom),
          c, ($urandom_range(0, 9) == 0),
          ($urandom_range(0, 49) == 0));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter DATA_W, default 32, operand/immediate width.
REQ-002 Parameter REG_W, default 5, register-index width.
REQ-003 clock  in  1  sole clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 id_valid  in  1  ID holds a real instruction.
REQ-006 id_rs, id_rt, id_dest  in  REG_W each  source 1, source 2, destination indices.
REQ-007 id_uses_rt  in  1  instruction reads id_rt as a register operand.
REQ-008 id_ctrl  in  ctrl_t  RegWrite, MemRead, MemWrite, MemToReg, ALUSrc, ALUOp[3:0].
REQ-009 id_rdata1, id_rdata2, id_imm  in  DATA_W each  register-file reads, sign-extended immediate.
REQ-010 flush  in  1  branch/jump taken in EX; discard instruction in ID.
REQ-011 stall  out  1  combinational; holds PC and IF/ID this cycle.
REQ-012 IDEX_valid  out  1  registered instruction valid.
REQ-013 IDEX_src1, IDEX_src2, IDEX_dest  out  REG_W each  registered indices consumed by the forwarding unit.
REQ-014 IDEX_ctrl  out  ctrl_t  registered control.
REQ-015 IDEX_rdata1, IDEX_rdata2, IDEX_imm  out  DATA_W each  registered operands.

Function
REQ-016 stall SHALL be 1 iff IDEX_valid && IDEX_ctrl.MemRead && IDEX_dest != 0 && id_valid && (IDEX_dest == id_rs || (id_uses_rt && IDEX_dest == id_rt)).
REQ-017 Normal cycle (no stall, no flush): all IDEX_* registers SHALL load ID inputs; IDEX_valid SHALL load id_valid; latency one cycle.
REQ-018 Stall cycle: a bubble SHALL be loaded (IDEX_valid=0, all IDEX_ctrl fields 0, indices 0, data 0); ID instruction is re-presented next cycle.
REQ-019 Stall SHALL last exactly one cycle per load-use pair; afterwards the load occupies EX/MEM and forwarding resolves it.
REQ-020 Flush cycle: a bubble SHALL be loaded; stall SHALL be forced 0 when flush=1 (flush wins over stall).
REQ-021 Bubble SHALL never assert RegWrite/MemWrite, so downstream forwarding never matches it.
REQ-022 id_valid=0 SHALL load a bubble regardless of other inputs.
REQ-023 Destination register 0 SHALL never cause a stall.

Reset
REQ-024 While reset=1 at a rising edge, IDEX_* registers SHALL take the bubble value; stall SHALL read 0 during the following cycle.
REQ-025 Reset asserted mid-stall SHALL override stall and flush; no pending stall survives reset.

Configuration
REQ-026 Macro ID_EX_STALL_COUNT_EN defined: extra output stall_count (out, 32) SHALL increment by 1 on every clock edge with stall=1 and reset=0, wrap 0xFFFFFFFF->0, reset to 0.
REQ-027 Macro undefined: stall_count port and counter SHALL not exist; all other behaviour identical.

Structure
REQ-028 Package mips_pkg SHALL hold ctrl_t (packed struct), alu_op_t, REG_ZERO constant and the CTRL_BUBBLE constant.
REQ-029 Load-use detection SHALL be a sub-module id_ex_hazard (combinational, REQ-016/020); the pipeline register stays in id_ex_stage.

Verification
REQ-030 lw $8 in IDEX (MemRead=1, dest=8), ID add rs=8 -> stall=1 one cycle, bubble in IDEX next, add enters IDEX the cycle after with src1=8.
REQ-031 lw dest=8, ID sw with rt=8, id_uses_rt=1 -> stall=1; same with id_uses_rt=0 -> stall=0.
REQ-032 lw dest=0, ID rs=0 -> stall=0, ID instruction loaded normally.
REQ-033 Stall condition plus flush=1 same cycle -> stall=0, bubble loaded, IDEX_ctrl all 0.
REQ-034 reset=1 during stall cycle -> next cycle IDEX_valid=0, stall=0; with ID_EX_STALL_COUNT_EN, stall_count=0.
REQ-035 ID_EX_STALL_COUNT_EN, three separate load-use pairs -> stall_count=3; preload 0xFFFFFFFF plus one stall -> 0.
